prog_rom_loader: RTL

- Writer side of the CPU's program memory. The CPU only reads program memory: it fetches 14-bit instruction words through its 11-bit MAR.
- This block receives a framed byte stream from the host link, assembles 14-bit instruction words, and writes them into the writable program memory at consecutive 11-bit addresses.
- Holds the CPU stalled (cpu_hold) while a frame is in progress. Reports completion and checksum errors.

---
 rtl/prog_rom_loader_pkg.sv | 19 +
 rtl/prog_rom_loader.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/prog_rom_loader_pkg.sv
// Shared constants and state encoding for the program-memory loader.
// Address/data widths must match the CPU PC/MAR and Program_Rom word width.
package prog_rom_loader_pkg;

    localparam int          PROG_ADDR_W    = 11;
    localparam int          PROG_DATA_W    = 14;
    localparam logic [7:0]  PROG_SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ADDR_HI = 3'd1,
        ADDR_LO = 3'd2,
        COUNT   = 3'd3,
        DATA_HI = 3'd4,
        DATA_LO = 3'd5,
        CHECK   = 3'd6
    } state_t;

endpackage

// File: rtl/prog_rom_loader.sv
// Assembles a framed host byte stream into instruction words and writes them
// to program memory, holding the CPU while a frame is in flight.
//
// state   | meaning
// IDLE    | hunting for SYNC_BYTE, all other bytes dropped
// ADDR_HI | expecting start address bits [ADDR_W-1:8]
// ADDR_LO | expecting start address bits [7:0]
// COUNT   | expecting word count (0 encodes 256)
// DATA_HI | expecting upper bits of the next word
// DATA_LO | expecting lower byte; acceptance issues the write
// CHECK   | expecting checksum byte, frame ends on acceptance
module prog_rom_loader
    import prog_rom_loader_pkg::*;
#(
    parameter int         ADDR_W    = PROG_ADDR_W,
    parameter int         DATA_W    = PROG_DATA_W,
    parameter logic [7:0] SYNC_BYTE = PROG_SYNC_BYTE
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);

    localparam int HI_W = DATA_W - 8;

    state_t              state, state_n;
    logic [ADDR_W-1:0]   addr, addr_n;
    logic [8:0]          cnt, cnt_n;
    logic [HI_W-1:0]     hi, hi_n;
    logic [7:0]          chk, chk_n, chk_sum;
    logic                wr_en_n, cpu_hold_n, done_n, err_n;
    logic [ADDR_W-1:0]   wr_addr_n;
    logic [DATA_W-1:0]   wr_data_n;
    logic                xfer;

    // The only stall source is the write cycle itself.
    assign in_ready = ~wr_en;
    assign xfer     = in_valid & in_ready;
    assign chk_sum  = chk + in_data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            addr     <= '0;
            cnt      <= '0;
            hi       <= '0;
            chk      <= '0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            cpu_hold <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= state_n;
            addr     <= addr_n;
            cnt      <= cnt_n;
            hi       <= hi_n;
            chk      <= chk_n;
            wr_en    <= wr_en_n;
            wr_addr  <= wr_addr_n;
            wr_data  <= wr_data_n;
            cpu_hold <= cpu_hold_n;
            done     <= done_n;
            err      <= err_n;
        end
    end

    always_comb begin
        state_n    = state;
        addr_n     = addr;
        cnt_n      = cnt;
        hi_n       = hi;
        chk_n      = chk;
        wr_en_n    = 1'b0;
        wr_addr_n  = wr_addr;
        wr_data_n  = wr_data;
        cpu_hold_n = cpu_hold;
        done_n     = 1'b0;
        err_n      = err;

        if (xfer) begin
            // Every byte after SYNC, CHK included, feeds the running sum.
            if (state != IDLE) begin
                chk_n = chk_sum;
            end
            unique case (state)
                IDLE: begin
                    if (in_data == SYNC_BYTE) begin
                        state_n    = ADDR_HI;
                        chk_n      = '0;
                        cpu_hold_n = 1'b1;
                        err_n      = 1'b0;
                    end
                end
                ADDR_HI: begin
                    addr_n  = {in_data[ADDR_W-9:0], addr[7:0]};
                    state_n = ADDR_LO;
                end
                ADDR_LO: begin
                    addr_n  = {addr[ADDR_W-1:8], in_data};
                    state_n = COUNT;
                end
                COUNT: begin
                    cnt_n   = (in_data == 8'd0) ? 9'd256 : {1'b0, in_data};
                    state_n = DATA_HI;
                end
                DATA_HI: begin
                    hi_n    = in_data[HI_W-1:0];
                    state_n = DATA_LO;
                end
                DATA_LO: begin
                    wr_en_n   = 1'b1;
                    wr_addr_n = addr;
                    wr_data_n = {hi, in_data};
                    addr_n    = addr + ADDR_W'(1);
                    cnt_n     = cnt - 9'd1;
                    state_n   = (cnt == 9'd1) ? CHECK : DATA_HI;
                end
                CHECK: begin
                    cpu_hold_n = 1'b0;
                    state_n    = IDLE;
                    if (chk_sum == 8'h00) begin
                        done_n = 1'b1;
                    end else begin
                        err_n = 1'b1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

endmodule
